// File: rtl/video_frame_sig.sv
// Frame-signature unit: on request, captures the next full vsync-to-vsync frame.
// It reports a CRC-32 over the visible pixels, the visible pixel and active line counts, and a size check.
module video_frame_sig #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        vga_blank,
    input  logic [23:0] video_rgb,
    input  logic        arm,
    output logic        busy,
    output logic        done,
    output logic [31:0] crc,
    output logic [19:0] pixel_count,
    output logic [9:0]  line_count,
    output logic        size_err
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [19:0] EXP_PIXELS  = 20'(H_VISIBLE * V_VISIBLE);
    localparam logic [9:0]  EXP_LINES   = 10'(V_VISIBLE);
    localparam logic [19:0] PIX_MAX     = '1;
    localparam logic [9:0]  LINE_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [19:0] pix_cnt_q, pix_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic        size_err_q, size_err_d;
    logic        vsync_q, vsync_d;
    logic        hsync_q, hsync_d;
    logic        blank_q, blank_d;

    logic        vs_fall;
    logic        line_start;
    logic        hsync_debug_unused;

    // One reflected CRC-32 byte step, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign vs_fall            = !vga_vsync && vsync_q;
    assign line_start         = !vga_blank && blank_q;
    assign hsync_debug_unused = hsync_q;

    always_comb begin
        vsync_d    = vga_vsync;
        hsync_d    = vga_hsync;
        blank_d    = vga_blank;
        state_d    = state_q;
        crc_d      = crc_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        size_err_d = size_err_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d    = CAPTURE;
                    crc_d      = CRC_INIT;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    size_err_d = 1'b0;
                end
            end
            CAPTURE: begin
                // The pixel on the closing vsync edge is excluded; it is blanked in legal timing.
                if (vs_fall) begin
                    state_d    = DONE;
                    size_err_d = (pix_cnt_q != EXP_PIXELS) || (line_cnt_q != EXP_LINES);
                end else if (!vga_blank) begin
                    crc_d = crc_byte(crc_byte(crc_byte(crc_q, video_rgb[7:0]),
                                              video_rgb[15:8]), video_rgb[23:16]);
                    if (pix_cnt_q != PIX_MAX) begin
                        pix_cnt_d = pix_cnt_q + 20'd1;
                    end
                    if (line_start && (line_cnt_q != LINE_MAX)) begin
                        line_cnt_d = line_cnt_q + 10'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            crc_q      <= CRC_INIT;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            size_err_q <= 1'b0;
            vsync_q    <= 1'b1;
            hsync_q    <= 1'b1;
            blank_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            size_err_q <= size_err_d;
            vsync_q    <= vsync_d;
            hsync_q    <= hsync_d;
            blank_q    <= blank_d;
        end
    end

    assign busy        = (state_q == WAIT_VS) || (state_q == CAPTURE);
    assign done        = (state_q == DONE);
    assign crc         = crc_q;
    assign pixel_count = pix_cnt_q;
    assign line_count  = line_cnt_q;
    assign size_err    = size_err_q;

endmodule

// File: tb/tb_video_frame_sig.sv
// Randomized self-checking bench for video_frame_sig in a 4x2 configuration.
// A table-driven CRC-32 and simple counters serve as the reference model.
module tb_video_frame_sig;

    localparam int H_VIS = 4;
    localparam int V_VIS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vga_hsync = 1'b1;
    logic        vga_vsync = 1'b1;
    logic        vga_blank = 1'b1;
    logic [23:0] video_rgb = '0;
    logic        arm = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] crc;
    logic [19:0] pixel_count;
    logic [9:0]  line_count;
    logic        size_err;

    int          errors = 0;
    int          checks = 0;

    logic [31:0] crc_table [256];
    logic [31:0] model_crc;
    int          model_pix;
    int          model_lines;

    video_frame_sig #(.H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS)) dut (
        .clk(clk),
        .reset(reset),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_blank(vga_blank),
        .video_rgb(video_rgb),
        .arm(arm),
        .busy(busy),
        .done(done),
        .crc(crc),
        .pixel_count(pixel_count),
        .line_count(line_count),
        .size_err(size_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelFold(input logic [31:0] c, input logic [7:0] b);
        logic [7:0] idx;
        idx = c[7:0] ^ b;
        return crc_table[idx] ^ (c >> 8);
    endfunction

    task automatic buildTable();
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
            crc_table[n] = c;
        end
    endtask

    task automatic pulseArm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
        checkOutput("busy_after_arm", {31'b0, busy}, 32'd1);
    endtask

    // Drives one frame: opening vsync, then n_lines lines of ppl visible pixels.
    task automatic applyStimulus(input int n_lines, input int ppl, input bit blank_all,
                                 input bit zero_rgb, input bit mid_arm);
        logic [23:0] px;
        model_crc   = 32'hFFFFFFFF;
        model_pix   = 0;
        model_lines = 0;
        @(negedge clk) begin vga_vsync = 1'b0; vga_blank = 1'b1; end
        @(negedge clk) vga_vsync = 1'b1;
        @(negedge clk);
        for (int l = 0; l < n_lines; l++) begin
            @(negedge clk) vga_hsync = 1'b0;
            @(negedge clk) vga_hsync = 1'b1;
            for (int p = 0; p < ppl; p++) begin
                px = zero_rgb ? 24'h000000 : 24'($urandom);
                @(negedge clk) begin
                    vga_blank = blank_all;
                    video_rgb = px;
                    arm       = mid_arm && (l == 0) && (p == 0);
                end
                if (!blank_all) begin
                    model_crc = modelFold(model_crc, px[7:0]);
                    model_crc = modelFold(model_crc, px[15:8]);
                    model_crc = modelFold(model_crc, px[23:16]);
                    model_pix++;
                    if (p == 0) model_lines++;
                end
            end
            @(negedge clk) begin vga_blank = 1'b1; video_rgb = '0; arm = 1'b0; end
        end
        @(negedge clk);
    endtask

    // Closing vsync, then counts done pulses over a bounded window.
    task automatic closeFrame(input bit arm_on_done);
        int pulses;
        pulses = 0;
        @(negedge clk) vga_vsync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) begin
                vga_vsync = 1'b1;
                arm = 1'b0;
                if (done) begin
                    pulses++;
                    checkOutput("busy_on_done", {31'b0, busy}, 32'd0);
                    if (arm_on_done) arm = 1'b1;
                end
            end
        end
        arm = 1'b0;
        checkOutput("done_pulses", 32'(pulses), 32'd1);
        checkOutput("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic checkResults(input string tag);
        logic exp_err;
        exp_err = (model_pix != H_VIS * V_VIS) || (model_lines != V_VIS);
        checkOutput({tag, "_crc"}, crc, model_crc);
        checkOutput({tag, "_pix"}, {12'b0, pixel_count}, 32'(model_pix));
        checkOutput({tag, "_lines"}, {22'b0, line_count}, 32'(model_lines));
        checkOutput({tag, "_size_err"}, {31'b0, size_err}, {31'b0, exp_err});
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_crc"}, crc, 32'hFFFFFFFF);
        checkOutput({tag, "_pix"}, {12'b0, pixel_count}, 32'd0);
        checkOutput({tag, "_lines"}, {22'b0, line_count}, 32'd0);
        checkOutput({tag, "_size_err"}, {31'b0, size_err}, 32'd0);
    endtask

    initial begin
        int dones;
        buildTable();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkResetState("reset");

        pulseArm();
        applyStimulus(2, 4, 1'b0, 1'b0, 1'b0);
        closeFrame(1'b0);
        checkResults("nominal");

        pulseArm();
        applyStimulus(2, 4, 1'b0, 1'b1, 1'b0);
        closeFrame(1'b0);
        checkResults("zero_rgb");

        pulseArm();
        applyStimulus(2, 4, 1'b1, 1'b0, 1'b0);
        closeFrame(1'b0);
        checkResults("all_blank");
        checkOutput("all_blank_err", {31'b0, size_err}, 32'd1);

        pulseArm();
        applyStimulus(3, 4, 1'b0, 1'b0, 1'b0);
        closeFrame(1'b0);
        checkResults("three_lines");

        pulseArm();
        applyStimulus(2, 4, 1'b0, 1'b0, 1'b1);
        closeFrame(1'b1);
        checkResults("rearm_ignored");
        repeat (3) @(negedge clk);
        checkOutput("rearm_still_idle", {31'b0, busy}, 32'd0);
        checkResults("rearm_hold");

        pulseArm();
        applyStimulus(2, 4, 1'b0, 1'b0, 1'b0);
        closeFrame(1'b0);
        checkResults("fresh");

        // Abort a capture with reset midway through the first line.
        pulseArm();
        @(negedge clk) vga_vsync = 1'b0;
        @(negedge clk) vga_vsync = 1'b1;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk) begin vga_blank = 1'b0; video_rgb = 24'($urandom); end
        end
        @(negedge clk) begin reset = 1'b1; vga_blank = 1'b1; end
        @(negedge clk) reset = 1'b0;
        checkResetState("abort");
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) if (done) dones++;
        end
        checkOutput("abort_no_done", 32'(dones), 32'd0);

        pulseArm();
        applyStimulus(2, 4, 1'b0, 1'b0, 1'b0);
        closeFrame(1'b0);
        checkResults("after_abort");

        for (int it = 0; it < 4; it++) begin
            pulseArm();
            applyStimulus($urandom_range(1, 3), $urandom_range(1, 5), 1'b0, 1'b0, 1'b0);
            closeFrame(1'b0);
            checkResults("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
